// File: rtl/sprite_motion_ctrl.sv
// Per-frame player sprite controller for the VGA renderer.
// Samples keycode and the sticky collision flag on each frame_sync pulse,
// steps the sprite, backs it out of walls with an input lockout, and
// times the walk animation.
// Optional: define SPRITE_WRAP_EN to wrap at screen edges instead of clamping.
module sprite_motion_ctrl #(
   parameter int unsigned X_INIT       = 320,
   parameter int unsigned Y_INIT       = 240,
   parameter int unsigned STEP         = 2,
   parameter int unsigned SIZE         = 32,
   parameter int unsigned X_MAX        = 639,
   parameter int unsigned Y_MAX        = 479,
   parameter int unsigned BLOCK_FRAMES = 8,
   parameter int unsigned ANIM_DIV     = 8
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       frame_sync,
   input  logic [7:0] keycode,
   input  logic       collision,
   output logic [9:0] spriteX,
   output logic [9:0] spriteY,
   output logic [9:0] sprite_size,
   output logic [7:0] dir_key,
   output logic       anim_phase,
   output logic       moving,
   output logic       blocked
);

   localparam int unsigned BCW = (BLOCK_FRAMES > 1) ? $clog2(BLOCK_FRAMES) : 1;
   localparam int unsigned ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   localparam logic [7:0] KEY_RIGHT = 8'h07;
   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_UP    = 8'h1A;
   localparam logic [7:0] KEY_DOWN  = 8'h16;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MOVE    = 2'd1;
   localparam logic [1:0] ST_BLOCKED = 2'd2;

   localparam logic [10:0]    STEP_W   = 11'(STEP);
   localparam logic [10:0]    LIM_X    = 11'(X_MAX + 1 - SIZE);
   localparam logic [10:0]    LIM_Y    = 11'(Y_MAX + 1 - SIZE);
   localparam logic [BCW-1:0] BLK_LAST = BCW'(BLOCK_FRAMES - 1);
   localparam logic [ACW-1:0] ANM_LAST = ACW'(ANIM_DIV - 1);

   logic [1:0]     state_q, state_d;
   logic [9:0]     x_q, x_d, y_q, y_d;
   logic [9:0]     prev_x_q, prev_x_d, prev_y_q, prev_y_d;
   logic [7:0]     dir_q, dir_d;
   logic [BCW-1:0] block_cnt_q, block_cnt_d;
   logic [ACW-1:0] anim_cnt_q, anim_cnt_d;
   logic           phase_q, phase_d;
   logic           moving_q, moving_d;
   logic           blocked_q, blocked_d;

   logic           key_valid_c;
   logic [9:0]     step_x_c, step_y_c;
   logic [10:0]    sum_x_c, sum_y_c;

   // Candidate position for this frame's keycode, bounded at the screen edges
   always_comb begin
      key_valid_c = 1'b0;
      step_x_c    = x_q;
      step_y_c    = y_q;
      sum_x_c     = {1'b0, x_q} + STEP_W;
      sum_y_c     = {1'b0, y_q} + STEP_W;
      case (keycode)
         KEY_RIGHT: begin
            key_valid_c = 1'b1;
`ifdef SPRITE_WRAP_EN
            step_x_c = (sum_x_c > LIM_X) ? 10'd0 : sum_x_c[9:0];
`else
            step_x_c = (sum_x_c > LIM_X) ? LIM_X[9:0] : sum_x_c[9:0];
`endif
         end
         KEY_LEFT: begin
            key_valid_c = 1'b1;
`ifdef SPRITE_WRAP_EN
            step_x_c = ({1'b0, x_q} < STEP_W) ? LIM_X[9:0] : x_q - STEP_W[9:0];
`else
            step_x_c = ({1'b0, x_q} < STEP_W) ? 10'd0 : x_q - STEP_W[9:0];
`endif
         end
         KEY_DOWN: begin
            key_valid_c = 1'b1;
`ifdef SPRITE_WRAP_EN
            step_y_c = (sum_y_c > LIM_Y) ? 10'd0 : sum_y_c[9:0];
`else
            step_y_c = (sum_y_c > LIM_Y) ? LIM_Y[9:0] : sum_y_c[9:0];
`endif
         end
         KEY_UP: begin
            key_valid_c = 1'b1;
`ifdef SPRITE_WRAP_EN
            step_y_c = ({1'b0, y_q} < STEP_W) ? LIM_Y[9:0] : y_q - STEP_W[9:0];
`else
            step_y_c = ({1'b0, y_q} < STEP_W) ? 10'd0 : y_q - STEP_W[9:0];
`endif
         end
         default: key_valid_c = 1'b0;
      endcase
   end

   // Next-state and output decisions, taken only on the frame_sync cycle
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      prev_x_d    = prev_x_q;
      prev_y_d    = prev_y_q;
      dir_d       = dir_q;
      block_cnt_d = block_cnt_q;
      anim_cnt_d  = anim_cnt_q;
      phase_d     = phase_q;
      moving_d    = moving_q;
      blocked_d   = blocked_q;
      if (frame_sync) begin
         if (collision && (state_q != ST_BLOCKED)) begin
            // Back out to the last position that was drawn without a hit
            x_d         = prev_x_q;
            y_d         = prev_y_q;
            block_cnt_d = BLK_LAST;
            state_d     = ST_BLOCKED;
            blocked_d   = 1'b1;
            moving_d    = 1'b0;
            anim_cnt_d  = '0;
            phase_d     = 1'b0;
         end else if (state_q == ST_BLOCKED) begin
            moving_d = 1'b0;
            if (block_cnt_q == '0) begin
               state_d   = ST_IDLE;
               blocked_d = 1'b0;
            end else begin
               block_cnt_d = block_cnt_q - BCW'(1);
            end
         end else if (key_valid_c) begin
            prev_x_d = x_q;
            prev_y_d = y_q;
            x_d      = step_x_c;
            y_d      = step_y_c;
            dir_d    = keycode;
            moving_d = 1'b1;
            state_d  = ST_MOVE;
            if (anim_cnt_q == ANM_LAST) begin
               anim_cnt_d = '0;
               phase_d    = ~phase_q;
            end else begin
               anim_cnt_d = anim_cnt_q + ACW'(1);
            end
         end else begin
            state_d    = ST_IDLE;
            moving_d   = 1'b0;
            anim_cnt_d = '0;
            phase_d    = 1'b0;
            prev_x_d   = x_q;
            prev_y_d   = y_q;
         end
      end
   end

   // State and output registers
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         x_q         <= 10'(X_INIT);
         y_q         <= 10'(Y_INIT);
         prev_x_q    <= 10'(X_INIT);
         prev_y_q    <= 10'(Y_INIT);
         dir_q       <= KEY_LEFT;
         block_cnt_q <= '0;
         anim_cnt_q  <= '0;
         phase_q     <= 1'b0;
         moving_q    <= 1'b0;
         blocked_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         prev_x_q    <= prev_x_d;
         prev_y_q    <= prev_y_d;
         dir_q       <= dir_d;
         block_cnt_q <= block_cnt_d;
         anim_cnt_q  <= anim_cnt_d;
         phase_q     <= phase_d;
         moving_q    <= moving_d;
         blocked_q   <= blocked_d;
      end
   end

   assign spriteX     = x_q;
   assign spriteY     = y_q;
   assign sprite_size = 10'(SIZE);
   assign dir_key     = dir_q;
   assign anim_phase  = phase_q;
   assign moving      = moving_q;
   assign blocked     = blocked_q;

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Per-frame controller that sequences the player sprite in the VGA renderer.
- Samples keycode and the renderer's sticky collision flag once per frame.
- Updates spriteX/spriteY and facing direction, backs the sprite out of walls, and runs walk-animation timing.
- Outputs feed the renderer's spriteX, spriteY, sprite_size and keycode-select inputs directly.

Parameters:
- X_INIT, 320, reset X position (top-left pixel of sprite)
- Y_INIT, 240, reset Y position
- STEP, 2, pixels moved per frame while a direction key is held
- SIZE, 32, sprite edge length; driven on sprite_size
- X_MAX, 639, last visible column
- Y_MAX, 479, last visible row
- BLOCK_FRAMES, 8, frames of input lockout after a collision
- ANIM_DIV, 8, frames per walk-animation phase

Ports:
- vga_clk  in  1  pixel clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- frame_sync  in  1  one-cycle pulse at start of vertical blank; collision is final for the frame just drawn
- keycode  in  8  USB keycode: 0x07 right, 0x04 left, 0x1A up, 0x16 down, anything else = no move
- collision  in  1  renderer's sticky wall-hit flag
- spriteX  out  10  sprite X position
- spriteY  out  10  sprite Y position
- sprite_size  out  10  constant SIZE
- dir_key  out  8  last accepted direction keycode; drives renderer sprite select
- anim_phase  out  1  walk frame select
- moving  out  1  high while a move step was taken this frame
- blocked  out  1  high during lockout

Behaviour:
- Reset values (async, reset_n low): spriteX=X_INIT, spriteY=Y_INIT, dir_key=0x04, anim_phase=0, moving=0, blocked=0.
- Reset internals: prevX=X_INIT, prevY=Y_INIT, block_cnt=0, anim_cnt=0, state=IDLE.
- Reset deassertion mid-frame: no update until the next frame_sync.
- All state changes occur only on the vga_clk edge where frame_sync=1. Outputs are registered and change one cycle after that edge; they are stable for the whole frame.
- States: IDLE, MOVE, BLOCKED.
- Priority at a frame_sync edge, highest first:
  1. collision=1 and state != BLOCKED:
     - spriteX/Y <= prevX/prevY; block_cnt <= BLOCK_FRAMES-1; state <= BLOCKED.
     - blocked=1, moving=0, anim_cnt=0, anim_phase=0.
     - dir_key unchanged.
  2. state=BLOCKED:
     - keycode ignored; collision ignored; position held.
     - If block_cnt==0, state <= IDLE and blocked <= 0; else block_cnt decrements.
     - Total lockout is exactly BLOCK_FRAMES frames.
  3. Valid direction keycode:
     - prevX/Y <= current position; step one axis by STEP; dir_key <= keycode; moving=1; state <= MOVE.
     - anim_cnt increments; on reaching ANIM_DIV-1 it wraps to 0 and anim_phase toggles.
  4. Otherwise:
     - state <= IDLE; moving=0; anim_cnt=0; anim_phase=0; position and dir_key held.
     - prevX/Y <= current position.
- Clamp rules, 10-bit unsigned; compute in 11 bits to avoid wrap:
  - Right: X = min(X+STEP, X_MAX+1-SIZE), i.e. 608 with defaults.
  - Left: X = (X<STEP) ? 0 : X-STEP.
  - Down: Y = min(Y+STEP, Y_MAX+1-SIZE), i.e. 448 with defaults.
  - Up: Y = (Y<STEP) ? 0 : Y-STEP.
  - A clamped step that does not change position still counts as moving=1.
- frame_sync asserted while reset_n is low: ignored.
- Keycode changing between frame_sync pulses: only the value present at the pulse matters.

Optional Feature:
- Macro: SPRITE_WRAP_EN.
- Defined:
  - Screen edges wrap instead of clamp.
  - Right past X_MAX+1-SIZE gives X=0; left below 0 gives X=X_MAX+1-SIZE. Y behaves the same with Y_MAX.
  - Collision handling is unchanged.
- Undefined: clamp rules above.

Test Plan:
- Reset: reset_n=0, then release -> spriteX=320, spriteY=240, dir_key=0x04, moving=0, blocked=0, no change until the first frame_sync.
- Move right: keycode=0x07 for 10 frame_sync pulses -> spriteX=340, spriteY=240, dir_key=0x07, moving=1; anim_phase toggles after frame 8.
- Left clamp: start X=1, keycode=0x04, one frame -> X=0; next frame X stays 0, moving=1.
- Bottom clamp: from Y=446, keycode=0x16 for 2 frames -> Y=448 then 448. With SPRITE_WRAP_EN, frame 2 gives Y=0.
- Collision: moving up from Y=240 to 238, collision=1 at next frame_sync -> Y=240 and blocked=1 for exactly 8 frames despite keycode=0x1A held; frame 9 moves to Y=238.
- Async reset mid-lockout: assert reset_n=0 during BLOCKED -> all outputs return to reset values immediately, blocked=0.
